// File: rtl/nx_node_store_mp_if.sv
// Bus bundle for the multi-port node instruction/control store.
// master = requester side (drives store/fetch/ctrl requests), slave = store.
interface nx_node_store_mp_if #(
  parameter int INSTR_WIDTH = 15,
  parameter int MAX_INSTRS  = 512,
  parameter int CTRL_WIDTH  = 12,
  parameter int MAX_CTRL    = 512,
  parameter int FETCH_PORTS = 2
);
  localparam int IA = $clog2(MAX_INSTRS);
  localparam int CA = $clog2(MAX_CTRL);

  logic [IA:0]                                instr_count;
  logic                                       store_full;
  logic [INSTR_WIDTH-1:0]                     store_data;
  logic                                       store_valid;
  logic                                       store_clear;
  logic [FETCH_PORTS-1:0][IA-1:0]             fetch_addr;
  logic [FETCH_PORTS-1:0]                     fetch_rd;
  logic [FETCH_PORTS-1:0][INSTR_WIDTH-1:0]    fetch_data;
  logic [FETCH_PORTS-1:0]                     fetch_stall;
  logic [CA-1:0]                              ctrl_addr;
  logic [CTRL_WIDTH-1:0]                      ctrl_wr_data;
  logic                                       ctrl_wr_en;
  logic                                       ctrl_rd_en;
  logic [CTRL_WIDTH-1:0]                      ctrl_rd_data;

  modport master (
    input  instr_count, store_full, fetch_data, fetch_stall, ctrl_rd_data,
    output store_data, store_valid, store_clear, fetch_addr, fetch_rd,
           ctrl_addr, ctrl_wr_data, ctrl_wr_en, ctrl_rd_en
  );

  modport slave (
    output instr_count, store_full, fetch_data, fetch_stall, ctrl_rd_data,
    input  store_data, store_valid, store_clear, fetch_addr, fetch_rd,
           ctrl_addr, ctrl_wr_data, ctrl_wr_en, ctrl_rd_en
  );
endinterface

// File: rtl/nx_node_store_mp.sv
// Multi-port node instruction/control store: sequentially loaded instruction
// RAM shared by FETCH_PORTS round-robin fetch channels, plus a control RAM.

module nx_node_store_lane #(
  parameter int W = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         gnt,
  input  logic         rd,
  input  logic [W-1:0] word,
  output logic [W-1:0] data,
  output logic         stall
);
  // Return register doubles as the hold register between grants.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)   data <= '0;
    else if (gnt) data <= word;
  end

  assign stall = rd && !gnt;
endmodule

module nx_node_store_mp #(
  parameter int INSTR_WIDTH = 15,
  parameter int MAX_INSTRS  = 512,
  parameter int CTRL_WIDTH  = 12,
  parameter int MAX_CTRL    = 512,
  parameter int FETCH_PORTS = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  nx_node_store_mp_if.slave bus
);
  localparam int IA = $clog2(MAX_INSTRS);
  localparam int CA = $clog2(MAX_CTRL);
  localparam int PW = (FETCH_PORTS > 1) ? $clog2(FETCH_PORTS) : 1;

  logic [INSTR_WIDTH-1:0] imem [MAX_INSTRS];
  logic [CTRL_WIDTH-1:0]  cmem [MAX_CTRL];

  logic [IA:0]            count;
  logic                   full;
  logic                   store_acc;

  logic [FETCH_PORTS-1:0] gnt;
  logic                   gnt_any;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          rr_ptr;
  logic [PW:0]            sum;
  logic [PW-1:0]          cand;
  logic [IA-1:0]          gnt_addr;
  logic [INSTR_WIDTH-1:0] rd_word;
  logic [CTRL_WIDTH-1:0]  ctrl_q;

  logic [FETCH_PORTS-1:0][INSTR_WIDTH-1:0] lane_data;
  logic [FETCH_PORTS-1:0]                  lane_stall;

  // Store path: clear dominates, full drops silently.
  assign full      = (count == (IA+1)'(MAX_INSTRS));
  assign store_acc = bus.store_valid && !full && !bus.store_clear;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)               count <= '0;
    else if (bus.store_clear) count <= '0;
    else if (store_acc)       count <= count + (IA+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (store_acc) imem[count[IA-1:0]] <= bus.store_data;
  end

  // Round-robin search starting at rr_ptr; a store owns the RAM port outright.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    if (!store_acc) begin
      for (int i = 0; i < FETCH_PORTS; i++) begin
        sum = {1'b0, rr_ptr} + (PW+1)'(i);
        if (sum >= (PW+1)'(FETCH_PORTS)) sum = sum - (PW+1)'(FETCH_PORTS);
        cand = sum[PW-1:0];
        if (!gnt_any && bus.fetch_rd[cand]) begin
          gnt_any   = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rr_ptr <= '0;
    else if (gnt_any)
      rr_ptr <= (gnt_idx == PW'(FETCH_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
  end

  // Addresses past the populated program read as zero; stale RAM is never exposed.
  assign gnt_addr = bus.fetch_addr[gnt_idx];
  assign rd_word  = ({1'b0, gnt_addr} < count) ? imem[gnt_addr] : '0;

  nx_node_store_lane #(.W(INSTR_WIDTH)) u_lane [FETCH_PORTS-1:0] (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .gnt   (gnt),
    .rd    (bus.fetch_rd),
    .word  (rd_word),
    .data  (lane_data),
    .stall (lane_stall)
  );

  // Control RAM: nonblocking write makes a same-cycle read see the old word.
  always_ff @(posedge clk_i) begin
    if (bus.ctrl_wr_en) cmem[bus.ctrl_addr] <= bus.ctrl_wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              ctrl_q <= '0;
    else if (bus.ctrl_rd_en) ctrl_q <= cmem[bus.ctrl_addr];
  end

  assign bus.instr_count  = count;
  assign bus.store_full   = full;
  assign bus.fetch_data   = lane_data;
  assign bus.fetch_stall  = lane_stall;
  assign bus.ctrl_rd_data = ctrl_q;
endmodule

// File: tb/tb_nx_node_store_mp.sv
// Directed bench for nx_node_store_mp (FP=4, MAX_INSTRS=8): the driver queues
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_nx_node_store_mp;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  nx_node_store_mp_if #(.INSTR_WIDTH(15), .MAX_INSTRS(8), .CTRL_WIDTH(12),
                        .MAX_CTRL(512), .FETCH_PORTS(4)) bus ();

  nx_node_store_mp #(.INSTR_WIDTH(15), .MAX_INSTRS(8), .CTRL_WIDTH(12),
                     .MAX_CTRL(512), .FETCH_PORTS(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic             sv;
    logic [14:0]      sd;
    logic             clr;
    logic [3:0]       rd;
    logic [3:0][2:0]  addr;
    logic             cwe;
    logic             cre;
    logic [8:0]       caddr;
    logic [11:0]      cwd;
    logic [3:0]       stall;
    logic [3:0][14:0] data;
    logic [3:0]       cnt;
    logic             full;
    logic [11:0]      cexp;
  } vec_t;

  vec_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t nv(input int cnt);
    vec_t v;
    v      = '0;
    v.cnt  = 4'(cnt);
    v.full = (cnt == 8);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.store_valid  = v.sv;
    bus.store_data   = v.sd;
    bus.store_clear  = v.clr;
    bus.fetch_rd     = v.rd;
    bus.fetch_addr   = v.addr;
    bus.ctrl_wr_en   = v.cwe;
    bus.ctrl_rd_en   = v.cre;
    bus.ctrl_addr    = v.caddr;
    bus.ctrl_wr_data = v.cwd;
  endtask

  task automatic step(input vec_t v);
    @(posedge clk_i);
    #1;
    drive(v);
    sbq.push_back(v);
  endtask

  // Monitor: grants seen last cycle land in the hold model, then this cycle's
  // stall/count/full and every channel's held data are compared.
  logic [3:0]       pend_g  = '0;
  logic [3:0][14:0] pend_d  = '0;
  logic [3:0][14:0] hold    = '0;
  logic             pend_c  = 1'b0;
  logic [11:0]      pend_cv = '0;
  logic [11:0]      chold   = '0;
  vec_t             m;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      sbq.delete();
      pend_g = '0;
      pend_c = 1'b0;
      hold   = '0;
      chold  = '0;
    end else begin
      for (int c = 0; c < 4; c++) if (pend_g[c]) hold[c] = pend_d[c];
      if (pend_c) chold = pend_cv;
      pend_g = '0;
      pend_c = 1'b0;
      if (sbq.size() > 0) begin
        m = sbq.pop_front();
        for (int c = 0; c < 4; c++)
          chk($sformatf("fetch_data[%0d]", c), 32'(bus.fetch_data[c]), 32'(hold[c]));
        chk("fetch_stall", 32'(bus.fetch_stall), 32'(m.stall));
        chk("instr_count", 32'(bus.instr_count), 32'(m.cnt));
        chk("store_full", 32'(bus.store_full), 32'(m.full));
        chk("ctrl_rd_data", 32'(bus.ctrl_rd_data), 32'(chold));
        pend_g  = m.rd & ~m.stall;
        pend_d  = m.data;
        pend_c  = m.cre;
        pend_cv = m.cexp;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " instr_count"}, 32'(bus.instr_count), 32'h0);
    chk({tag, " store_full"}, 32'(bus.store_full), 32'h0);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s fetch_data[%0d]", tag, c), 32'(bus.fetch_data[c]), 32'h0);
    chk({tag, " ctrl_rd_data"}, 32'(bus.ctrl_rd_data), 32'h0);
  endtask

  logic [14:0] img [4] = '{15'h11, 15'h22, 15'h33, 15'h44};

  initial begin
    vec_t v;
    drive(nv(0));
    @(posedge clk_i);
    #3;
    chk_reset_outputs("reset");
    rst_i = 1'b1;

    // Load three words, then a lone fetch on ch0.
    v = nv(0); v.sv = 1'b1; v.sd = 15'h11; step(v);
    v = nv(1); v.sv = 1'b1; v.sd = 15'h22; step(v);
    v = nv(2); v.sv = 1'b1; v.sd = 15'h33; step(v);
    v = nv(3); v.rd = 4'b0001; v.addr[0] = 3'd1; v.data[0] = 15'h22; step(v);

    // Store collides with ch1 fetch: ch1 waits one cycle.
    v = nv(3); v.sv = 1'b1; v.sd = 15'h44; v.rd = 4'b0010; v.stall = 4'b0010; step(v);
    v = nv(4); v.rd = 4'b0010; v.data[1] = 15'h11; step(v);
    // Pointer now 2; ch3 alone moves it back to 0.
    v = nv(4); v.rd = 4'b1000; v.addr[3] = 3'd3; v.data[3] = 15'h44; step(v);

    // All four channels contend; each switches address after its first grant.
    for (int k = 0; k < 8; k++) begin
      v = nv(4);
      v.rd = 4'b1111;
      for (int c = 0; c < 4; c++) v.addr[c] = (k <= c) ? 3'(c) : 3'(3 - c);
      v.stall = 4'b1111 & ~(4'b0001 << (k % 4));
      v.data[k % 4] = (k < 4) ? img[k % 4] : img[3 - (k % 4)];
      step(v);
    end

    // Fill to saturation; ninth store dropped.
    v = nv(4); v.clr = 1'b1; step(v);
    for (int i = 0; i < 8; i++) begin
      v = nv(i); v.sv = 1'b1; v.sd = 15'h100 + 15'(i); step(v);
    end
    v = nv(8); v.sv = 1'b1; v.sd = 15'h1ff; step(v);
    v = nv(8); v.rd = 4'b0001; v.addr[0] = 3'd7; v.data[0] = 15'h107; step(v);
    v = nv(8); v.rd = 4'b0001; v.addr[0] = 3'd0; v.data[0] = 15'h100; step(v);
    v = nv(8); v.clr = 1'b1; v.sv = 1'b1; v.sd = 15'h2aa; step(v);
    v = nv(0); v.clr = 1'b1; v.sv = 1'b1; v.sd = 15'h2bb; step(v);
    v = nv(0); step(v);

    // Reload a short program.
    v = nv(0); v.sv = 1'b1; v.sd = 15'h11; step(v);
    v = nv(1); v.sv = 1'b1; v.sd = 15'h22; step(v);
    v = nv(2); v.sv = 1'b1; v.sd = 15'h33; step(v);

    // Control RAM read-before-write.
    v = nv(3); v.cwe = 1'b1; v.caddr = 9'd5; v.cwd = 12'h123; step(v);
    v = nv(3); v.cwe = 1'b1; v.cre = 1'b1; v.caddr = 9'd5; v.cwd = 12'habc; v.cexp = 12'h123; step(v);
    v = nv(3); v.cre = 1'b1; v.caddr = 9'd5; v.cexp = 12'habc; step(v);
    v = nv(3); v.caddr = 9'd7; step(v);

    // Fetch past the program end: RAM still holds 0x106 there, must read 0.
    v = nv(3); v.rd = 4'b0100; v.addr[2] = 3'd6; v.data[2] = 15'h0; step(v);

    // Grant ch3 and yank reset before the return edge.
    v = nv(3); v.rd = 4'b1000; v.addr[3] = 3'd0; v.data[3] = 15'h11; step(v);
    #2;
    rst_i = 1'b0;
    drive(nv(0));
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;

    // Pointer back at 0: ch0 wins a four-way request; dropped return never appears.
    v = nv(0); v.sv = 1'b1; v.sd = 15'h55; step(v);
    v = nv(1); v.rd = 4'b1111; v.stall = 4'b1110; v.data[0] = 15'h55; step(v);
    v = nv(1); v.rd = 4'b1110; v.stall = 4'b1100; v.data[1] = 15'h55; step(v);
    v = nv(1); v.rd = 4'b1100; v.stall = 4'b1000; v.data[2] = 15'h55; step(v);
    v = nv(1); v.rd = 4'b1000; v.data[3] = 15'h55; step(v);
    v = nv(1); step(v);

    repeat (2) @(posedge clk_i);
    #6;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
